rv32_mc_control: RTL and testbench

Multi-cycle RV32I control unit: a state machine that sequences each instruction through fetch, decode, execute, memory and write-back, and drives the datapath control fields for each step. It waits on a memory ready handshake and, optionally, on an iterative multiply/divide unit. It retires halt and illegal opcodes into a sticky halt state. The block sits between the instruction register and the multi-cycle datapath, and replaces the single-cycle combinational decoder for the multi-cycle CPU build.

---
 rtl/rv32_ctrl_pkg.sv | 47 ++++
 rtl/rv32_decode.sv | 109 ++++++++++
 rtl/rv32_mc_control.sv | 165 ++++++++++++++++
 tb/tb_rv32_mc_control.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I control unit
// Contents: opcode constants, ExtOp / ALUBSrc / Branch / ALUctr encodings, FSM state enum.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_HALT   = 7'b0000000;

  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [2:0] EXT_I = 3'b000;
  localparam logic [2:0] EXT_U = 3'b001;
  localparam logic [2:0] EXT_S = 3'b010;
  localparam logic [2:0] EXT_B = 3'b011;
  localparam logic [2:0] EXT_J = 3'b100;

  localparam logic [1:0] ALUB_RS2  = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_JAL  = 3'b001;
  localparam logic [2:0] BR_JALR = 3'b010;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/rv32_decode.sv
// rtl/rv32_decode.sv - combinational instruction decode for the multi-cycle control unit
// Inputs : instr (IR contents).
// Outputs: ext_op, alu_a_src, alu_b_src, alu_ctr, branch, mem_op (datapath fields),
//          is_load/is_store/is_branch/is_md (class flags), is_halt, illegal_op.
module rv32_decode
  import rv32_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 0
) (
  input  logic [31:0] instr,
  output logic [2:0]  ext_op,
  output logic        alu_a_src,
  output logic [1:0]  alu_b_src,
  output logic [3:0]  alu_ctr,
  output logic [2:0]  branch,
  output logic [2:0]  mem_op,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_md,
  output logic        is_halt,
  output logic        illegal_op
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign mem_op = funct3;

  // Register specifiers are consumed by the datapath, not by control.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ext_op     = EXT_I;
    alu_a_src  = 1'b0;
    alu_b_src  = ALUB_RS2;
    alu_ctr    = ALU_ADD;
    branch     = BR_NONE;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_md      = 1'b0;
    is_halt    = 1'b0;
    illegal_op = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ext_op    = EXT_U;
        alu_b_src = ALUB_IMM;
        alu_ctr   = ALU_LUI;
      end
      OPC_AUIPC: begin
        ext_op    = EXT_U;
        alu_a_src = 1'b1;
        alu_b_src = ALUB_IMM;
      end
      OPC_JAL: begin
        ext_op    = EXT_J;
        alu_a_src = 1'b1;
        alu_b_src = ALUB_FOUR;
        branch    = BR_JAL;
      end
      OPC_JALR: begin
        ext_op    = EXT_I;
        alu_a_src = 1'b1;
        alu_b_src = ALUB_FOUR;
        branch    = BR_JALR;
      end
      OPC_BRANCH: begin
        ext_op    = EXT_B;
        is_branch = 1'b1;
        alu_ctr   = funct3[1] ? ALU_SLTU : ALU_SLT;
        // funct3 bit 2 separates eq/ne from lt/ge; bit 0 selects the negated form.
        branch    = {1'b1, funct3[2], funct3[0]};
      end
      OPC_LOAD: begin
        ext_op    = EXT_I;
        alu_b_src = ALUB_IMM;
        is_load   = 1'b1;
      end
      OPC_STORE: begin
        ext_op    = EXT_S;
        alu_b_src = ALUB_IMM;
        is_store  = 1'b1;
      end
      OPC_OPIMM: begin
        ext_op    = EXT_I;
        alu_b_src = ALUB_IMM;
        // instr[30] is an immediate bit for addi, so only srai takes the modifier.
        alu_ctr   = {(funct3 == 3'b101) & instr[30], funct3};
      end
      OPC_OP: begin
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M != 0) is_md = 1'b1;
          else               illegal_op = 1'b1;
        end else begin
          alu_ctr = {((funct3 == 3'b000) || (funct3 == 3'b101)) & instr[30], funct3};
        end
      end
      OPC_HALT: is_halt = 1'b1;
      default:  illegal_op = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32_mc_control.sv
// rtl/rv32_mc_control.sv - multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT)
// Inputs : clk, rst_n (async active-low), instr, mem_ready, md_done.
// Outputs: ir_wr, pc_wr, iord, mem_rd, mem_wr, mem_op, reg_wr, mem_to_reg, md_start, md_sel,
//          ext_op, alu_a_src, alu_b_src, alu_ctr, branch, halted, illegal, instret.
module rv32_mc_control
  import rv32_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 0,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [2:0]       mem_op,
  output logic             reg_wr,
  output logic             mem_to_reg,
  output logic             md_start,
  output logic             md_sel,
  output logic [2:0]       ext_op,
  output logic             alu_a_src,
  output logic [1:0]       alu_b_src,
  output logic [3:0]       alu_ctr,
  output logic [2:0]       branch,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state;
  logic       md_busy;   // md_start already issued for the current EXEC visit
  logic       ready;

  logic [2:0] d_ext_op;
  logic       d_alu_a_src;
  logic [1:0] d_alu_b_src;
  logic [3:0] d_alu_ctr;
  logic [2:0] d_branch;
  logic [2:0] d_mem_op;
  logic       d_load, d_store, d_branch_cls, d_md, d_halt, d_illegal;

  rv32_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr      (instr),
    .ext_op     (d_ext_op),
    .alu_a_src  (d_alu_a_src),
    .alu_b_src  (d_alu_b_src),
    .alu_ctr    (d_alu_ctr),
    .branch     (d_branch),
    .mem_op     (d_mem_op),
    .is_load    (d_load),
    .is_store   (d_store),
    .is_branch  (d_branch_cls),
    .is_md      (d_md),
    .is_halt    (d_halt),
    .illegal_op (d_illegal)
  );

  assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      md_busy <= 1'b0;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      md_busy <= 1'b0;
      if (pc_wr) instret <= instret + CNT_W'(1);
      case (state)
        S_IDLE:   state <= S_FETCH;
        S_FETCH:  if (ready) state <= S_DECODE;
        S_DECODE: begin
          if (d_halt) begin
            state <= S_HALT;
          end else if (d_illegal) begin
            state   <= S_HALT;
            illegal <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (d_branch_cls) begin
            state <= S_FETCH;
          end else if (d_load || d_store) begin
            state <= S_MEM;
          end else if (d_md) begin
            // md_done in the start cycle is accepted immediately.
            if (md_done) state <= S_WB;
            else         md_busy <= 1'b1;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM:    if (ready) state <= d_load ? S_WB : S_FETCH;
        S_WB:     state <= S_FETCH;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Handshake strobes (ir_wr, store pc_wr) must follow mem_ready in the same cycle,
  // so outputs are decoded from the registered state plus live inputs.
  always_comb begin
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    mem_to_reg = 1'b0;
    md_start   = 1'b0;
    md_sel     = 1'b0;
    ext_op     = 3'b000;
    alu_a_src  = 1'b0;
    alu_b_src  = 2'b00;
    alu_ctr    = 4'b0000;
    branch     = 3'b000;
    mem_op     = 3'b000;
    halted     = (state == S_HALT);
    if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
      ext_op    = d_ext_op;
      alu_a_src = d_alu_a_src;
      alu_b_src = d_alu_b_src;
      alu_ctr   = d_alu_ctr;
      branch    = d_branch;
      mem_op    = d_mem_op;
    end
    case (state)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_wr  = ready;
      end
      S_EXEC: begin
        pc_wr    = d_branch_cls;
        md_start = d_md & ~md_busy;
      end
      S_MEM: begin
        iord = 1'b1;
        if (d_load) begin
          mem_rd = 1'b1;
        end else begin
          mem_wr = 1'b1;
          pc_wr  = ready;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        pc_wr      = 1'b1;
        mem_to_reg = d_load;
        md_sel     = d_md;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32_mc_control.sv
// tb/tb_rv32_mc_control.sv - self-checking bench for rv32_mc_control
module tb_rv32_mc_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        ra_n, rb_n;
  logic [31:0] instr;
  logic        mem_ready, md_done;

  logic a_ir_wr, a_pc_wr, a_iord, a_mem_rd, a_mem_wr, a_reg_wr, a_mem_to_reg;
  logic a_md_start, a_md_sel, a_alu_a_src, a_halted, a_illegal;
  logic [2:0] a_mem_op, a_ext_op, a_branch;
  logic [1:0] a_alu_b_src;
  logic [3:0] a_alu_ctr;
  logic [31:0] a_instret;

  logic b_ir_wr, b_pc_wr, b_iord, b_mem_rd, b_mem_wr, b_reg_wr, b_mem_to_reg;
  logic b_md_start, b_md_sel, b_alu_a_src, b_halted, b_illegal;
  logic [2:0] b_mem_op, b_ext_op, b_branch;
  logic [1:0] b_alu_b_src;
  logic [3:0] b_alu_ctr;
  logic [3:0] b_instret;

  rv32_mc_control #(.ENABLE_M(1), .MEM_WAIT(1), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(ra_n), .instr(instr), .mem_ready(mem_ready), .md_done(md_done),
    .ir_wr(a_ir_wr), .pc_wr(a_pc_wr), .iord(a_iord), .mem_rd(a_mem_rd), .mem_wr(a_mem_wr),
    .mem_op(a_mem_op), .reg_wr(a_reg_wr), .mem_to_reg(a_mem_to_reg), .md_start(a_md_start),
    .md_sel(a_md_sel), .ext_op(a_ext_op), .alu_a_src(a_alu_a_src), .alu_b_src(a_alu_b_src),
    .alu_ctr(a_alu_ctr), .branch(a_branch), .halted(a_halted), .illegal(a_illegal),
    .instret(a_instret)
  );

  rv32_mc_control #(.ENABLE_M(0), .MEM_WAIT(0), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rb_n), .instr(instr), .mem_ready(mem_ready), .md_done(md_done),
    .ir_wr(b_ir_wr), .pc_wr(b_pc_wr), .iord(b_iord), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr),
    .mem_op(b_mem_op), .reg_wr(b_reg_wr), .mem_to_reg(b_mem_to_reg), .md_start(b_md_start),
    .md_sel(b_md_sel), .ext_op(b_ext_op), .alu_a_src(b_alu_a_src), .alu_b_src(b_alu_b_src),
    .alu_ctr(b_alu_ctr), .branch(b_branch), .halted(b_halted), .illegal(b_illegal),
    .instret(b_instret)
  );

  logic [26:0] obs_a, obs_b;
  assign obs_a = {a_ir_wr, a_pc_wr, a_iord, a_mem_rd, a_mem_wr, a_mem_op, a_reg_wr, a_mem_to_reg,
                  a_md_start, a_md_sel, a_ext_op, a_alu_a_src, a_alu_b_src, a_alu_ctr, a_branch,
                  a_halted, a_illegal};
  assign obs_b = {b_ir_wr, b_pc_wr, b_iord, b_mem_rd, b_mem_wr, b_mem_op, b_reg_wr, b_mem_to_reg,
                  b_md_start, b_md_sel, b_ext_op, b_alu_a_src, b_alu_b_src, b_alu_ctr, b_branch,
                  b_halted, b_illegal};

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_a;
  logic [3:0]  exp_b;

  localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4, PH = 5;
  localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_MD = 4, C_HALT = 5, C_ILL = 6;

  function automatic int ref_class(input logic [31:0] ins, input bit en_m);
    case (ins[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0010011: return C_ALU;
      7'b1100011: return C_BR;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0110011: begin
        if (ins[31:25] == 7'b0000001) return en_m ? C_MD : C_ILL;
        return C_ALU;
      end
      7'b0000000: return C_HALT;
      default:    return C_ILL;
    endcase
  endfunction

  // {ext_op, alu_a_src, alu_b_src, alu_ctr, branch}
  function automatic logic [12:0] ref_dec(input logic [31:0] ins);
    logic [2:0] ext, br, f3;
    logic       a;
    logic [1:0] b;
    logic [3:0] alu;
    ext = 3'b000; br = 3'b000; a = 1'b0; b = 2'b00; alu = 4'b0000; f3 = ins[14:12];
    case (ins[6:0])
      7'b0110111: begin ext = 3'b001; b = 2'b10; alu = 4'b1111; end
      7'b0010111: begin ext = 3'b001; a = 1'b1; b = 2'b10; end
      7'b1101111: begin ext = 3'b100; a = 1'b1; b = 2'b01; br = 3'b001; end
      7'b1100111: begin ext = 3'b000; a = 1'b1; b = 2'b01; br = 3'b010; end
      7'b1100011: begin
        ext = 3'b011;
        alu = (f3 >= 3'd6) ? 4'b0011 : 4'b0010;
        case (f3)
          3'd0:       br = 3'b100;
          3'd1:       br = 3'b101;
          3'd4, 3'd6: br = 3'b110;
          default:    br = 3'b111;
        endcase
      end
      7'b0000011: begin ext = 3'b000; b = 2'b10; end
      7'b0100011: begin ext = 3'b010; b = 2'b10; end
      7'b0010011: begin b = 2'b10; alu = (f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3}; end
      7'b0110011: begin
        if (ins[31:25] != 7'b0000001)
          alu = (f3 == 3'd0 || f3 == 3'd5) ? {ins[30], f3} : {1'b0, f3};
      end
      default: ;
    endcase
    return {ext, a, b, alu, br};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [2:0]  f3;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {r[31:7], 7'b0110111};
      1: return {r[31:7], 7'b0010111};
      2: return {r[31:7], 7'b1101111};
      3: return {r[31:15], 3'b000, r[11:7], 7'b1100111};
      4: begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd4; 3: f3 = 3'd5; 4: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        return {r[31:15], f3, r[11:7], 7'b1100011};
      end
      5: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
        endcase
        return {r[31:15], f3, r[11:7], 7'b0000011};
      end
      6: begin
        f3 = 3'($urandom_range(0, 2));
        return {r[31:15], f3, r[11:7], 7'b0100011};
      end
      7: begin
        f3 = r[14:12];
        f7 = (f3 == 3'd1) ? 7'b0 : (f3 == 3'd5) ? {1'b0, r[30], 5'b0} : r[31:25];
        return {f7, r[24:15], f3, r[11:7], 7'b0010011};
      end
      8: begin
        f3 = r[14:12];
        f7 = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, r[30], 5'b0} : 7'b0;
        return {f7, r[24:15], f3, r[11:7], 7'b0110011};
      end
      default: return {7'b0000001, r[24:15], r[14:12], r[11:7], 7'b0110011};
    endcase
  endfunction

  // Drives one instruction through DUT d (0 = a, 1 = b) from its FETCH cycle, comparing
  // every cycle's outputs against the phase sequence the instruction class implies.
  // Returns with the DUT one posedge past the last cycle, #1 later.
  task automatic run_instr(input int d, input logic [31:0] ins, input int fw, input int mw,
                           input int mdn, input int stop_after, output int nbad);
    int q[$];
    int cls, fc, mc, ec;
    bit wen;
    logic [12:0] f;
    logic [26:0] e, got;
    logic rdy;
    logic e_ir, e_pc, e_iord, e_rd, e_wr, e_reg, e_m2r, e_mds, e_mdsel, e_a, e_halt, e_ill;
    logic [2:0] e_mop, e_ext, e_br;
    logic [1:0] e_b;
    logic [3:0] e_alu;
    nbad = 0;
    wen  = (d == 0);
    cls  = ref_class(ins, d == 0);
    f    = ref_dec(ins);
    repeat (wen ? fw + 1 : 1) q.push_back(PF);
    q.push_back(PD);
    case (cls)
      C_HALT, C_ILL: repeat (4) q.push_back(PH);
      C_BR:    q.push_back(PE);
      C_LOAD:  begin q.push_back(PE); repeat (wen ? mw + 1 : 1) q.push_back(PM); q.push_back(PW); end
      C_STORE: begin q.push_back(PE); repeat (wen ? mw + 1 : 1) q.push_back(PM); end
      C_MD:    begin repeat (mdn + 1) q.push_back(PE); q.push_back(PW); end
      default: begin q.push_back(PE); q.push_back(PW); end
    endcase
    instr = ins;
    fc = 0; mc = 0; ec = 0;
    for (int i = 0; i < q.size() && i < stop_after; i++) begin
      @(negedge clk);
      mem_ready = (q[i] == PF) ? (fc >= fw) : (q[i] == PM) ? (mc >= mw) : 1'($urandom);
      md_done   = (q[i] == PE && cls == C_MD) ? (ec >= mdn) : 1'($urandom);
      rdy       = wen ? mem_ready : 1'b1;
      #1;
      {e_ir, e_pc, e_iord, e_rd, e_wr, e_reg, e_m2r, e_mds, e_mdsel, e_halt, e_ill} = '0;
      {e_mop, e_ext, e_a, e_b, e_alu, e_br} = '0;
      if (q[i] inside {PD, PE, PM, PW}) begin
        {e_ext, e_a, e_b, e_alu, e_br} = f;
        e_mop = ins[14:12];
      end
      case (q[i])
        PF: begin e_rd = 1'b1; e_ir = rdy; end
        PE: begin e_pc = (cls == C_BR); e_mds = (cls == C_MD) && (ec == 0); end
        PM: begin
          e_iord = 1'b1;
          if (cls == C_LOAD) e_rd = 1'b1;
          else begin e_wr = 1'b1; e_pc = rdy; end
        end
        PW: begin e_reg = 1'b1; e_pc = 1'b1; e_m2r = (cls == C_LOAD); e_mdsel = (cls == C_MD); end
        PH: begin e_halt = 1'b1; e_ill = (cls == C_ILL); end
        default: ;
      endcase
      e = {e_ir, e_pc, e_iord, e_rd, e_wr, e_mop, e_reg, e_m2r, e_mds, e_mdsel,
           e_ext, e_a, e_b, e_alu, e_br, e_halt, e_ill};
      got = (d == 0) ? obs_a : obs_b;
      if (got !== e) begin
        nbad++;
        $display("  instr %h cycle %0d phase %0d: got %h want %h", ins, i, q[i], got, e);
      end
      if (q[i] == PF) fc++;
      if (q[i] == PM) mc++;
      if (q[i] == PE) ec++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int d);
    @(negedge clk);
    ra_n = 1'b0; rb_n = 1'b0; instr = '0; mem_ready = 1'b0; md_done = 1'b0;
    @(negedge clk);
    if (d == 0) ra_n = 1'b1; else rb_n = 1'b1;
    @(posedge clk);
    #1;
    exp_a = '0;
    exp_b = '0;
  endtask

  task automatic test_reset();
    ra_n = 1'b0; rb_n = 1'b0; instr = 32'h0000a103; mem_ready = 1'b1; md_done = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if ({obs_a, a_instret} !== '0) begin bad++; $display("FAIL reset_a_outputs: got %h want 0", {obs_a, a_instret}); end
    total++;
    if ({obs_b, b_instret} !== '0) begin bad++; $display("FAIL reset_b_outputs: got %h want 0", {obs_b, b_instret}); end
    ra_n = 1'b1;
    #1;
    total++;
    if (obs_a !== '0) begin bad++; $display("FAIL idle_outputs: got %h want 0", obs_a); end
    @(posedge clk);
    #1;
    total++;
    if ({a_mem_rd, a_iord, a_ir_wr} !== 3'b101) begin
      bad++; $display("FAIL idle_to_fetch: got %b want 101", {a_mem_rd, a_iord, a_ir_wr});
    end
  endtask

  task automatic test_addi_nowait();
    int nb;
    apply_reset(1);
    run_instr(1, 32'h00500093, 2, 0, 0, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL addi_trace: got %0d bad cycles want 0", nb); end
    exp_b = 4'((exp_b + 1) % 16);
    total++;
    if (b_instret !== exp_b) begin bad++; $display("FAIL addi_instret: got %0d want %0d", b_instret, exp_b); end
  endtask

  task automatic test_load_waits();
    int nb;
    apply_reset(0);
    run_instr(0, 32'h0000a103, 2, 3, 0, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL lw_trace: got %0d bad cycles want 0", nb); end
    exp_a = exp_a + 1;
    total++;
    if (a_instret !== exp_a) begin bad++; $display("FAIL lw_instret: got %0d want %0d", a_instret, exp_a); end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    total++;
    if ({a_mem_rd, a_iord, a_ir_wr, a_reg_wr} !== 4'b1000) begin
      bad++; $display("FAIL lw_next_fetch: got %b want 1000", {a_mem_rd, a_iord, a_ir_wr, a_reg_wr});
    end
  endtask

  task automatic test_branch_store();
    int nb;
    apply_reset(0);
    run_instr(0, 32'h0020e463, 1, 0, 0, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL bltu_trace: got %0d bad cycles want 0", nb); end
    run_instr(0, 32'h0020a223, 0, 2, 0, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL sw_trace: got %0d bad cycles want 0", nb); end
    total++;
    if (a_instret !== 32'd2) begin bad++; $display("FAIL bltu_sw_instret: got %0d want 2", a_instret); end
  endtask

  task automatic test_mul();
    int nb;
    apply_reset(0);
    run_instr(0, 32'h022081b3, 0, 0, 7, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL mul_trace: got %0d bad cycles want 0", nb); end
    total++;
    if (a_instret !== 32'd1) begin bad++; $display("FAIL mul_instret: got %0d want 1", a_instret); end
    run_instr(0, 32'h022081b3, 0, 0, 0, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL mul_same_cycle_done: got %0d bad cycles want 0", nb); end
  endtask

  task automatic test_mul_illegal();
    int nb;
    apply_reset(1);
    run_instr(1, 32'h022081b3, 0, 0, 7, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL mul_illegal_trace: got %0d bad cycles want 0", nb); end
    total++;
    if ({b_halted, b_illegal, b_instret} !== {2'b11, 4'd0}) begin
      bad++; $display("FAIL mul_illegal_flags: got %b want 110000", {b_halted, b_illegal, b_instret});
    end
  endtask

  task automatic test_halt();
    int nb;
    apply_reset(0);
    run_instr(0, 32'h00500093, 0, 0, 0, 99, nb);
    run_instr(0, 32'h00000000, 1, 0, 0, 99, nb);
    total++;
    if (nb !== 0) begin bad++; $display("FAIL halt_trace: got %0d bad cycles want 0", nb); end
    total++;
    if ({a_halted, a_illegal} !== 2'b10 || a_instret !== 32'd1) begin
      bad++; $display("FAIL halt_flags: got %b/%0d want 10/1", {a_halted, a_illegal}, a_instret);
    end
    @(negedge clk);
    ra_n = 1'b0;
    #1;
    total++;
    if ({a_halted, a_instret} !== 33'd0) begin
      bad++; $display("FAIL halt_reset: got %b/%0d want 0/0", a_halted, a_instret);
    end
    @(negedge clk);
    ra_n = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    int nb;
    apply_reset(0);
    run_instr(0, 32'h00500093, 0, 0, 0, 99, nb);
    run_instr(0, 32'h0000a103, 0, 3, 0, 5, nb);
    total++;
    if (nb !== 0 || a_instret !== 32'd1) begin
      bad++; $display("FAIL mid_load_pre: got %0d bad cycles, instret %0d want 0, 1", nb, a_instret);
    end
    mem_ready = 1'b1;
    ra_n = 1'b0;
    #1;
    total++;
    if ({obs_a, a_instret} !== '0) begin bad++; $display("FAIL mid_load_abort: got %h want 0", {obs_a, a_instret}); end
    @(negedge clk);
    #1;
    total++;
    if ({a_reg_wr, a_pc_wr, a_instret} !== '0) begin
      bad++; $display("FAIL mid_load_no_wb: got %h want 0", {a_reg_wr, a_pc_wr, a_instret});
    end
    ra_n = 1'b1;
  endtask

  task automatic test_random();
    int nb;
    logic [31:0] ins;
    apply_reset(0);
    for (int k = 0; k < 40; k++) begin
      ins = rand_instr();
      run_instr(0, ins, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 5), 99, nb);
      exp_a = exp_a + 1;
      total++;
      if (nb !== 0) begin bad++; $display("FAIL random_trace %h: got %0d bad cycles want 0", ins, nb); end
      total++;
      if (a_instret !== exp_a) begin bad++; $display("FAIL random_instret %h: got %0d want %0d", ins, a_instret, exp_a); end
    end
  endtask

  task automatic test_wrap();
    int nb;
    logic [31:0] r;
    apply_reset(1);
    for (int k = 0; k < 17; k++) begin
      r = $urandom;
      run_instr(1, {r[31:15], (r[14] ? 3'b100 : 3'b000) | {2'b00, r[12]}, r[11:7], 7'b1100011},
                0, 0, 0, 99, nb);
      exp_b = 4'((exp_b + 1) % 16);
      total++;
      if (nb !== 0 || b_instret !== exp_b) begin
        bad++; $display("FAIL wrap_%0d: got %0d bad cycles, instret %0d want 0, %0d", k, nb, b_instret, exp_b);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi_nowait();
    test_load_waits();
    test_branch_store();
    test_mul();
    test_mul_illegal();
    test_halt();
    test_reset_mid_load();
    test_random();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
